// File: rtl/rca16_pipe_sub.sv
// rtl/rca16_pipe_sub.sv - pipelined ripple-borrow subtractor, one 4-bit slice per stage
// Valid/ready handshake on both sides; the whole pipe advances or stalls together.

module rca16_pipe_sub #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout
);

    localparam int STAGES = W / 4;

    logic en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    function automatic logic [4:0] sub4(input logic [3:0] x, input logic [3:0] y, input logic bi);
        logic [3:0] s;
        logic       br;
        s  = '0;
        br = bi;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, s};
    endfunction

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            // DW difference bits are resolved after this stage; HW operand bits still pending
            localparam int DW = 4 * (k + 1);
            localparam int HW = W - DW;

            logic          vld_q;
            logic          brw_q;
            logic [DW-1:0] dlo_q;
            logic [DW-1:0] dlo_d;
            logic [3:0]    a_sl;
            logic [3:0]    b_sl;
            logic          bin_sl;
            logic          vld_d;
            logic [4:0]    res_d;

            assign res_d = sub4(a_sl, b_sl, bin_sl);

            if (k == 0) begin : g_first
                assign a_sl   = a[3:0];
                assign b_sl   = b[3:0];
                assign bin_sl = bin;
                assign vld_d  = in_valid & in_ready;
                assign dlo_d  = res_d[3:0];
            end else begin : g_next
                assign a_sl   = g_st[k-1].g_fwd.ahi_q[3:0];
                assign b_sl   = g_st[k-1].g_fwd.bhi_q[3:0];
                assign bin_sl = g_st[k-1].brw_q;
                assign vld_d  = g_st[k-1].vld_q;
                assign dlo_d  = {res_d[3:0], g_st[k-1].dlo_q};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    brw_q <= 1'b0;
                    dlo_q <= '0;
                end else if (en) begin
                    vld_q <= vld_d;
                    brw_q <= res_d[4];
                    dlo_q <= dlo_d;
                end
            end

            if (HW > 0) begin : g_fwd
                logic [HW-1:0] ahi_q;
                logic [HW-1:0] bhi_q;
                logic [HW-1:0] ahi_d;
                logic [HW-1:0] bhi_d;

                if (k == 0) begin : g_first
                    assign ahi_d = a[W-1:4];
                    assign bhi_d = b[W-1:4];
                end else begin : g_next
                    assign ahi_d = g_st[k-1].g_fwd.ahi_q[HW+3:4];
                    assign bhi_d = g_st[k-1].g_fwd.bhi_q[HW+3:4];
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ahi_q <= '0;
                        bhi_q <= '0;
                    end else if (en) begin
                        ahi_q <= ahi_d;
                        bhi_q <= bhi_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_st[STAGES-1].vld_q;
    assign d         = g_st[STAGES-1].dlo_q;
    assign bout      = g_st[STAGES-1].brw_q;

endmodule

// File: tb/tb_rca16_pipe_sub.sv
// tb/tb_rca16_pipe_sub.sv - bench for rca16_pipe_sub
// Scoreboard of (a - b - bin) at W+1 bits plus directed literal expectations.

module tb_rca16_pipe_sub;

    localparam int W      = 16;
    localparam int STAGES = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;

    always #5 clk = ~clk;

    rca16_pipe_sub #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_pop = 0;
    logic [W:0]   exp_q[$];
    logic         rst_pend  = 1'b0;
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_b;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard and per-cycle protocol checks, sampled mid-cycle
    always @(negedge clk) begin
        logic [W:0] e;
        check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (rst_pend) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_d", {16'd0, d}, 32'd0);
            check("rst_bout", {31'd0, bout}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end else if (hold_pend) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", {15'd0, bout, d}, {15'd0, hold_b, hold_d});
        end
        if (rst) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_result: got d=%0h bout=%0b expected no result at %0t", d, bout, $time);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("result", {15'd0, bout, d}, {15'd0, e});
                    n_pop++;
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_d    = d;
            hold_b    = bout;
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        end
        rst_pend = rst;
    end

    // caller is just past a rising edge; returns just past the accepting edge
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int n;
        a = av;
        b = bv;
        bin = bi;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] ed, input logic eb);
        int n;
        @(posedge clk);
        #1;
        send(av, bv, bi);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 12);
        check({name, "_latency"}, n, STAGES);
        check({name, "_d"}, {16'd0, d}, {16'd0, ed});
        check({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
        @(negedge clk);
        check({name, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 300);
        check({name, "_drained"}, {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          n;
        int          run;
        int          cnt;
        int          cyc;
        logic        acc;
        logic [31:0] t;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);

        single("single", 16'h1234, 16'h0235, 1'b1, 16'h0FFE, 1'b0);
        single("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        single("zero_bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        single("ones_bin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        single("msb", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
        single("small", 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1);

        // back-to-back stream
        n0 = n_pop;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 21; i++) begin
                    t = 32'd1 << i;
                    a = t[15:0];
                    t = 32'd2 << i;
                    b = t[15:0];
                    bin = i[0];
                    in_valid = 1'b1;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 40);
                check("stream_start", {31'd0, out_valid}, 32'd1);
                run = 1;
                repeat (20) begin
                    @(negedge clk);
                    if (out_valid) run++;
                end
                check("stream_run", run, 21);
                @(negedge clk);
                check("stream_end", {31'd0, out_valid}, 32'd0);
            end
        join
        drain("stream");
        check("stream_count", n_pop - n0, 21);

        // backpressure with the output held
        n0 = n_pop;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(16'h1111, 16'h0001, 1'b0);
                send(16'h0000, 16'h0001, 1'b1);
                send(16'hABCD, 16'hABCD, 1'b0);
                send(16'h7FFF, 16'h8000, 1'b0);
                send(16'h00F0, 16'h000F, 1'b1);
                send(16'hFFFF, 16'h0000, 1'b1);
                send(16'h1000, 16'h0FFF, 1'b1);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(out_valid && !in_ready) && n < 40);
                check("bp_full", {31'd0, out_valid}, 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_count", n_pop - n0, 7);

        // reset with three operations in flight, operand offered during reset
        @(posedge clk);
        #1;
        send(16'h0F0F, 16'h0101, 1'b0);
        send(16'h2222, 16'h1111, 1'b1);
        send(16'h0000, 16'h0005, 1'b0);
        rst = 1'b1;
        a = 16'h5555;
        b = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_d", {16'd0, d}, 32'd0);
        check("mid_rst_bout", {31'd0, bout}, 32'd0);
        run = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) run++;
        end
        check("mid_rst_no_stale", run, 0);
        single("after_rst", 16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0);

        // random traffic
        n0 = n_pop;
        @(posedge clk);
        #1;
        cnt = 0;
        cyc = 0;
        while (cnt < 10000 && cyc < 80000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) cnt++;
            if (!in_valid || acc) begin
                in_valid = (cnt < 10000) && ($urandom_range(3) != 0);
                a = 16'($urandom);
                b = 16'($urandom);
                bin = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(3) != 0);
        end
        check("rand_accepted", cnt, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand");
        check("rand_count", n_pop - n0, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
